// File: rtl/sort_block_packer.sv
// Serial sample packer: fills ping-pong banks of 4*QUADS samples and drains each
// closed bank as QUADS consecutive quads, with BlkIn marking the first quad.
module sort_block_packer #(
   parameter int unsigned DW      = 8,
   parameter int unsigned QUADS   = 8,
   parameter int unsigned BLK_GAP = 0,
   parameter int          PAD_VAL = -128
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   input  logic          s_flush,
   output logic          s_ready,
   output logic          BlkIn,
   output logic          QuadValid,
   output logic [DW-1:0] In1,
   output logic [DW-1:0] In2,
   output logic [DW-1:0] In3,
   output logic [DW-1:0] In4
);

   localparam int unsigned Depth   = 4 * QUADS;
   localparam int unsigned AW      = $clog2(Depth);
   localparam int unsigned PW      = $clog2(Depth + 1);
   localparam int unsigned QW      = (QUADS > 1) ? $clog2(QUADS) : 1;
   localparam int unsigned GW      = (BLK_GAP > 1) ? $clog2(BLK_GAP) : 1;
   localparam int unsigned GapLast = (BLK_GAP > 0) ? BLK_GAP - 1 : 0;
   localparam logic [DW-1:0] PadVal = DW'(PAD_VAL);

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

   // Write side
   logic [DW-1:0] mem_q [2][Depth];
   logic [PW-1:0] len_q [2];
   logic [1:0]    full_q;
   logic [1:0]    full_d;
   logic          wr_bank_q;
   logic          wr_bank_d;
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] wr_ptr_d;
   logic          s_ready_q;
   logic          s_ready_d;
   logic          acc;
   logic [PW-1:0] wr_cnt;
   logic          close;

   // Drain side
   state_e        state_q;
   state_e        state_d;
   logic [QW-1:0] quad_q;
   logic [QW-1:0] quad_d;
   logic [GW-1:0] gap_q;
   logic [GW-1:0] gap_d;
   logic          rd_bank_q;
   logic          rd_bank_d;
   logic          free;
   logic          load;
   logic [QW-1:0] rd_quad;
   logic [PW-1:0] rd_pos  [4];
   logic [DW-1:0] rd_data [4];
   logic          blk_q;
   logic          blk_d;
   logic          qv_q;
   logic          qv_d;
   logic [DW-1:0] out_q [4];
   logic [DW-1:0] out_d [4];

   assign s_ready   = s_ready_q;
   assign BlkIn     = blk_q;
   assign QuadValid = qv_q;
   assign In1       = out_q[0];
   assign In2       = out_q[1];
   assign In3       = out_q[2];
   assign In4       = out_q[3];

   always_comb begin
      acc    = s_valid & s_ready_q;
      wr_cnt = wr_ptr_q + PW'(acc);
      // A sample taken alongside s_flush is counted before the bank closes.
      close  = (wr_cnt == PW'(Depth)) | (s_flush & (wr_cnt != '0));
   end

   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      wr_ptr_d  = wr_cnt;
      if (close) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
         wr_ptr_d          = '0;
      end
      if (free) begin
         full_d[rd_bank_q] = 1'b0;
      end
      s_ready_d = ~full_d[wr_bank_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         wr_ptr_q  <= '0;
         s_ready_q <= 1'b0;
         len_q[0]  <= '0;
         len_q[1]  <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         wr_ptr_q  <= wr_ptr_d;
         s_ready_q <= s_ready_d;
         if (close) begin
            len_q[wr_bank_q] <= wr_cnt;
         end
      end
   end

   // Bank storage needs no reset: the full flags and lengths gate every read.
   always_ff @(posedge clk) begin
      if (acc) begin
         mem_q[wr_bank_q][wr_ptr_q[AW-1:0]] <= s_data;
      end
   end

   // Entries past the recorded fill length of a flushed bank read as padding.
   always_comb begin
      rd_quad = (state_q == StSend) ? quad_q : '0;
      for (int j = 0; j < 4; j++) begin
         rd_pos[j]  = PW'({rd_quad, 2'b00}) + PW'(j);
         rd_data[j] = (rd_pos[j] < len_q[rd_bank_q]) ? mem_q[rd_bank_q][rd_pos[j][AW-1:0]]
                                                      : PadVal;
      end
   end

   always_comb begin
      state_d   = state_q;
      quad_d    = quad_q;
      gap_d     = gap_q;
      rd_bank_d = rd_bank_q;
      free      = 1'b0;
      load      = 1'b0;
      blk_d     = 1'b0;
      qv_d      = 1'b0;
      for (int j = 0; j < 4; j++) begin
         out_d[j] = '0;
      end

      unique case (state_q)
         StIdle: begin
            if (full_q[rd_bank_q]) begin
               load  = 1'b1;
               blk_d = 1'b1;
            end
         end
         StSend: begin
            load = 1'b1;
         end
         StGap: begin
            if (gap_q == GW'(GapLast)) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (load) begin
         qv_d = 1'b1;
         for (int j = 0; j < 4; j++) begin
            out_d[j] = rd_data[j];
         end
         // The last quad is already captured in the output registers, so the
         // bank can be released on the same edge.
         if (rd_quad == QW'(QUADS - 1)) begin
            free      = 1'b1;
            rd_bank_d = ~rd_bank_q;
            quad_d    = '0;
            gap_d     = '0;
            state_d   = (BLK_GAP > 0) ? StGap : StIdle;
         end else begin
            quad_d  = rd_quad + QW'(1);
            state_d = StSend;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         quad_q    <= '0;
         gap_q     <= '0;
         rd_bank_q <= 1'b0;
         blk_q     <= 1'b0;
         qv_q      <= 1'b0;
         for (int j = 0; j < 4; j++) begin
            out_q[j] <= '0;
         end
      end else begin
         state_q   <= state_d;
         quad_q    <= quad_d;
         gap_q     <= gap_d;
         rd_bank_q <= rd_bank_d;
         blk_q     <= blk_d;
         qv_q      <= qv_d;
         for (int j = 0; j < 4; j++) begin
            out_q[j] <= out_d[j];
         end
      end
   end

endmodule

// File: tb/tb_sort_block_packer.sv
// Bench for sort_block_packer: two instances (BLK_GAP 0 and 40) share the stimulus;
// each has a queue-of-blocks reference model fed by its own accepted samples.
module tb_sort_block_packer;

   localparam int unsigned DW    = 8;
   localparam int unsigned QUADS = 8;
   localparam int          BLK   = 4 * QUADS;
   localparam int          GAP1  = 40;
   localparam int          EB    = 4096;
   localparam int          NB    = 256;
   localparam logic [DW-1:0] PAD = 8'h80;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data  = '0;
   logic          s_flush = 1'b0;
   logic          rdy [2];
   logic          blk [2];
   logic          qv  [2];
   logic [DW-1:0] o1  [2];
   logic [DW-1:0] o2  [2];
   logic [DW-1:0] o3  [2];
   logic [DW-1:0] o4  [2];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [DW-1:0] expb    [2][EB];
   int            head    [2];
   int            tail    [2];
   logic [DW-1:0] curb    [2][BLK];
   int            curn    [2];
   int            qn      [2];
   int            blk_t   [2][NB];
   logic [DW-1:0] blk_a   [2][NB];
   int            blk_n   [2];
   int            close_t [2][NB];
   int            close_n [2];
   int            stall_n [2];

   always #5 clk = ~clk;

   sort_block_packer #(.DW(DW), .QUADS(QUADS), .BLK_GAP(0), .PAD_VAL(-128)) dut0 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_flush(s_flush),
      .s_ready(rdy[0]), .BlkIn(blk[0]), .QuadValid(qv[0]),
      .In1(o1[0]), .In2(o2[0]), .In3(o3[0]), .In4(o4[0])
   );

   sort_block_packer #(.DW(DW), .QUADS(QUADS), .BLK_GAP(GAP1), .PAD_VAL(-128)) dut1 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_flush(s_flush),
      .s_ready(rdy[1]), .BlkIn(blk[1]), .QuadValid(qv[1]),
      .In1(o1[1]), .In2(o2[1]), .In3(o3[1]), .In4(o4[1])
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Runs at the falling edge: checks outputs, then books what the next edge accepts.
   task automatic model_step(input int g);
      int minsp;
      minsp = (g == 0) ? QUADS : QUADS + GAP1;
      if (!rst_n) begin
         chk("reset_outputs", {rdy[g], blk[g], qv[g], o1[g], o2[g], o3[g], o4[g]}, '0);
         head[g] = 0;
         tail[g] = 0;
         curn[g] = 0;
         qn[g]   = 0;
      end else begin
         if (qv[g]) begin
            chk("quad_expected", 64'(tail[g] - head[g] >= 4), 1);
            if (tail[g] - head[g] >= 4) begin
               chk("in1", o1[g], expb[g][head[g] % EB]);
               chk("in2", o2[g], expb[g][(head[g] + 1) % EB]);
               chk("in3", o3[g], expb[g][(head[g] + 2) % EB]);
               chk("in4", o4[g], expb[g][(head[g] + 3) % EB]);
               head[g] += 4;
            end
            chk("blkin_first_quad", blk[g], 64'(qn[g] == 0));
            if (blk[g]) begin
               if (blk_n[g] > 0) begin
                  chk("block_spacing", 64'(cyc - blk_t[g][(blk_n[g] - 1) % NB] >= minsp), 1);
               end
               blk_t[g][blk_n[g] % NB] = cyc;
               blk_a[g][blk_n[g] % NB] = o1[g];
               blk_n[g]++;
            end
            qn[g] = (qn[g] + 1) % QUADS;
         end else begin
            chk("idle_outputs", {blk[g], o1[g], o2[g], o3[g], o4[g]}, '0);
            chk("no_bubble", qn[g], 0);
         end
         if (s_valid && !rdy[g]) stall_n[g]++;
         if (s_valid && rdy[g]) begin
            curb[g][curn[g]] = s_data;
            curn[g]++;
         end
         if (curn[g] == BLK || (s_flush && curn[g] > 0)) begin
            for (int k = 0; k < BLK; k++) begin
               expb[g][tail[g] % EB] = (k < curn[g]) ? curb[g][k] : PAD;
               tail[g]++;
            end
            close_t[g][close_n[g] % NB] = cyc + 1;
            close_n[g]++;
            curn[g] = 0;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step(0);
      model_step(1);
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_flush = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic pulse_flush();
      s_valid = 1'b0;
      s_flush = 1'b1;
      cycle();
      s_flush = 1'b0;
   endtask

   // mode 0: base+i, 1: random, 2: 10,20,30,...; s_data is 7 whenever dut g is not ready.
   task automatic feed(input int n, input int mode, input int base, input int g,
                       input int gap_pct, input int flush_pct);
      int            i;
      int            guard;
      bit            go;
      bit            acc;
      logic [DW-1:0] v;
      i     = 0;
      guard = 0;
      while (i < n && guard < 4000) begin
         go = ($urandom_range(99) >= gap_pct);
         case (mode)
            0:       v = DW'(base + i);
            1:       v = DW'($urandom);
            default: v = DW'((i + 1) * 10);
         endcase
         s_valid = go;
         s_data  = (go && rdy[g]) ? v : 8'd7;
         s_flush = ($urandom_range(99) < flush_pct);
         acc     = go && rdy[g];
         cycle();
         if (acc) i++;
         guard++;
      end
      s_valid = 1'b0;
      s_flush = 1'b0;
      chk("feed_budget", i, n);
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      s_valid = 1'b0;
      s_flush = 1'b0;
      while ((head[0] != tail[0] || head[1] != tail[1] || qv[0] || qv[1]) && w < 3000) begin
         cycle();
         w++;
      end
      chk("drain_done", 64'(w < 3000), 1);
      idle(2);
   endtask

   initial begin
      int b0;
      int c0;
      int s0;
      int w;
      for (int g = 0; g < 2; g++) begin
         head[g]    = 0;
         tail[g]    = 0;
         curn[g]    = 0;
         qn[g]      = 0;
         blk_n[g]   = 0;
         close_n[g] = 0;
         stall_n[g] = 0;
      end
      @(posedge clk);
      #1;
      idle(3);
      rst_n = 1'b1;
      chk("ready_before_edge", {rdy[0], rdy[1]}, 2'b00);
      cycle();
      chk("ready_after_edge", {rdy[0], rdy[1]}, 2'b11);

      // T1: 0..31 continuous
      b0 = blk_n[0];
      c0 = close_n[0];
      feed(32, 0, 0, 0, 0, 0);
      wait_drain();
      chk("t1_blocks", blk_n[0] - b0, 1);
      chk("t1_latency", blk_t[0][b0 % NB] - close_t[0][c0 % NB], 1);
      chk("t1_head", blk_a[0][b0 % NB], 8'h00);

      // T2: -128..-65 back-to-back
      b0 = blk_n[0];
      s0 = stall_n[0];
      feed(64, 0, 128, 0, 0, 0);
      chk("t2_ready_held", stall_n[0] - s0, 0);
      wait_drain();
      chk("t2_blocks", blk_n[0] - b0, 2);
      chk("t2_spacing", blk_t[0][(b0 + 1) % NB] - blk_t[0][b0 % NB], 32);
      chk("t2_block2_head", blk_a[0][(b0 + 1) % NB], 8'hA0);

      // T3: five samples then flush
      b0 = blk_n[0];
      feed(5, 2, 0, 0, 0, 0);
      pulse_flush();
      wait_drain();
      chk("t3_blocks", blk_n[0] - b0, 1);
      chk("t3_head", blk_a[0][b0 % NB], 8'd10);

      // T4/T6: 160 samples into the gapped instance; stalled cycles carry 7
      s0 = stall_n[1];
      feed(160, 0, 0, 1, 0, 0);
      chk("t4_ready_drop", 64'(stall_n[1] - s0 > 0), 1);
      pulse_flush();
      wait_drain();

      // T5: reset at drain beat 3
      feed(32, 1, 0, 0, 0, 0);
      w = 0;
      while (!(qv[0] && blk[0]) && w < 200) begin
         cycle();
         w++;
      end
      chk("t5_block_start", 64'(w < 200), 1);
      idle(3);
      rst_n = 1'b0;
      #1;
      chk("t5_async_clear0", {rdy[0], blk[0], qv[0], o1[0], o2[0], o3[0], o4[0]}, '0);
      chk("t5_async_clear1", {rdy[1], blk[1], qv[1], o1[1], o2[1], o3[1], o4[1]}, '0);
      idle(2);
      rst_n = 1'b1;
      chk("t5_ready_low", rdy[0], 1'b0);
      cycle();
      chk("t5_ready_up", rdy[0], 1'b1);
      b0 = blk_n[0];
      idle(40);
      chk("t5_no_blkin", blk_n[0] - b0, 0);
      feed(32, 0, 100, 0, 0, 0);
      wait_drain();
      chk("t5_blocks", blk_n[0] - b0, 1);
      chk("t5_new_head", blk_a[0][b0 % NB], 8'd100);

      // Random traffic with gaps and flushes
      feed(300, 1, 0, 0, 25, 5);
      pulse_flush();
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
